// File: rtl/adder_share_arb_if.sv
// =============================================================================
// adder_share_arb_if : request/result bundle for the shared adder arbiter
// Rev 1.0
// =============================================================================
`default_nettype none

interface adder_share_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [IDW-1:0]        res_id;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_cout;
    logic                  res_ovf;
    logic                  busy;

    modport master (
        output req_valid, req_a, req_b, req_cin, res_ready,
        input  req_ready, res_valid, res_id, res_sum, res_cout, res_ovf, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, res_ready,
        output req_ready, res_valid, res_id, res_sum, res_cout, res_ovf, busy
    );
endinterface

`default_nettype wire

// File: rtl/adder_share_arb.sv
// =============================================================================
// adder_share_arb : round-robin arbiter sharing one ripple-carry adder
// Rev 1.0
// =============================================================================
`default_nettype none

module adder_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    adder_share_arb_if.slave   bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [WIDTH-1:0] op_a_q,      op_a_d;
    logic [WIDTH-1:0] op_b_q,      op_b_d;
    logic             op_cin_q,    op_cin_d;
    logic [IDW-1:0]   op_id_q,     op_id_d;
    logic             res_valid_q, res_valid_d;
    logic [IDW-1:0]   res_id_q,    res_id_d;
    logic [WIDTH-1:0] res_sum_q,   res_sum_d;
    logic             res_cout_q,  res_cout_d;
    logic             res_ovf_q,   res_ovf_d;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   scan_idx;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_cin;
    logic [NREQ-1:0]  req_ready_w;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;
    logic             carry;

    // Scan from rr_ptr upward with wrap; the first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_idx) begin
                sel_a   = bus.req_a[i*WIDTH +: WIDTH];
                sel_b   = bus.req_b[i*WIDTH +: WIDTH];
                sel_cin = bus.req_cin[i];
            end
        end
    end

    always_comb begin
        req_ready_w = '0;
        if (rst_n && (state_q == S_IDLE) && grant_found) begin
            req_ready_w[grant_idx] = 1'b1;
        end
    end

    // Full-adder chain walked LSB to MSB so the carry ripples bit by bit.
    always_comb begin
        add_sum = '0;
        carry   = op_cin_q;
        for (int i = 0; i < WIDTH; i++) begin
            add_sum[i] = op_a_q[i] ^ op_b_q[i] ^ carry;
            carry      = (op_a_q[i] & op_b_q[i]) | (carry & (op_a_q[i] ^ op_b_q[i]));
        end
        add_cout = carry;
        add_ovf  = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                   (add_sum[WIDTH-1] != op_a_q[WIDTH-1]);
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_cin_d    = op_cin_q;
        op_id_d     = op_id_q;
        res_valid_d = res_valid_q;
        res_id_d    = res_id_q;
        res_sum_d   = res_sum_q;
        res_cout_d  = res_cout_q;
        res_ovf_d   = res_ovf_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    op_a_d   = sel_a;
                    op_b_d   = sel_b;
                    op_cin_d = sel_cin;
                    op_id_d  = grant_idx;
                    rr_ptr_d = IDW'((int'(grant_idx) + 1) % NREQ);
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                res_sum_d   = add_sum;
                res_cout_d  = add_cout;
                res_ovf_d   = add_ovf;
                res_id_d    = op_id_q;
                res_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_cin_q    <= 1'b0;
            op_id_q     <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_sum_q   <= '0;
            res_cout_q  <= 1'b0;
            res_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_cin_q    <= op_cin_d;
            op_id_q     <= op_id_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_sum_q   <= res_sum_d;
            res_cout_q  <= res_cout_d;
            res_ovf_q   <= res_ovf_d;
        end
    end

    assign bus.req_ready = req_ready_w;
    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_sum   = res_sum_q;
    assign bus.res_cout  = res_cout_q;
    assign bus.res_ovf   = res_ovf_q;
    assign bus.busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire
